seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Display back end for the stopwatch. Consumes the six 4-bit BCD digits d..i and drives a common-anode, 6-digit multiplexed 7-segment display (FND).
- d is the most significant (leftmost) digit and i the least significant.
- Latches a coherent frame once per scan cycle so digits never tear, and inserts a ghosting blank between digit switches.

Parameters:
- SCAN_DIV, 50000: clocks per digit slot (1 kHz slot rate at 50 MHz); minimum 2.
- BLANK_CYC, 2: clocks at the start of each slot with all commons off; must be < SCAN_DIV.
- DP_MASK, 6'b000100: decimal point enable per digit; bit5 = d … bit0 = i.

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous reset, active-low
- d  in  4  BCD digit, position 5 (leftmost)
- e  in  4  BCD digit, position 4
- f  in  4  BCD digit, position 3
- g  in  4  BCD digit, position 2
- h  in  4  BCD digit, position 1
- i  in  4  BCD digit, position 0 (rightmost)
- seg_n  out  7  segments, active-low; bit0 = a … bit6 = g
- dp_n  out  1  decimal point, active-low
- com_n  out  6  digit commons, active-low; com_n[k] enables position k

Behaviour:
- Clock and reset: one clock. reset is asynchronous, active-low, named clk / reset_n. All state and outputs are registered.
- Reset values: prescaler = 0, slot index idx = 5, blank counter = 0, frame registers = 0, com_n = 6'b111111, seg_n = 7'h7F, dp_n = 1. An assert mid-scan blanks the outputs immediately (asynchronous).
- Prescaler: counts 0..SCAN_DIV-1. tick is high when prescaler == SCAN_DIV-1.
- On the tick edge:
  - prescaler → 0.
  - idx → (idx == 0) ? 5 : idx-1. Scan order is d, e, f, g, h, i; this is the only state sequence.
  - com_n → all ones.
  - Blank counter loads BLANK_CYC.
  - seg_n and dp_n are loaded for the new idx.
- Blank phase: while the blank counter is ≠ 0, it decrements and com_n stays all ones. On the edge where it reaches 0, com_n[idx] goes low.
  - With BLANK_CYC = 0, com_n[idx] goes low on the tick edge itself.
- Frame capture: on the tick edge where idx goes 0 → 5, all six inputs are captured into the frame registers. seg_n for position 5 on that same edge decodes the incoming d value, not the stale frame.
  - The first tick after reset is a wrap: first digit d is lit at clock SCAN_DIV + BLANK_CYC after reset release.
- Decode:
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - 10–15: dash, 0111111 (segment g only)
- dp_n = ~DP_MASK[idx], loaded with seg_n.
- Input changes between captures are ignored. Full frame period = 6·SCAN_DIV clocks.

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN.
- Defined: leading-zero blanking is computed at frame capture. Position k ∈ {5,4,3,2} is blanked (seg_n = 7'h7F, dp_n = 1) when its captured digit is 0 and every higher position is also 0. Positions 1 and 0 are never blanked. com_n timing is unchanged.
- Undefined: all digits are always displayed.

Decomposition:
- Package seg7_pkg holds:
  - NUM_DIGITS = 6
  - seg code constants SEG_0..SEG_9, SEG_DASH, SEG_OFF
  - the position-index type
- One sub-module, seg7_decoder: combinational 4-bit BCD → 7-bit active-low code, dash for values ≥ 10. Used once per slot on the muxed digit.

Test Plan (SCAN_DIV = 4, BLANK_CYC = 1, 20 ns clock):
1. Reset: reset_n low for 50 ns → com_n = 111111, seg_n = 7F, dp_n = 1 throughout. After release, com_n = 011111 first at clock 5 with seg_n = decode(d).
2. Static d..i = 1,2,3,4,5,6 → com_n walks 011111, 101111, 110111, 111011, 111101, 111110, each low for 3 clocks after 1 blank clock. seg_n = 1111001, 0100100, 0110000, 0011001, 0010010, 0000010.
3. Tearing: change all inputs to 9 while position 3 is lit → positions 2..0 still show 4, 5, 6. The next frame shows 0010000 on all six positions.
4. Invalid BCD: g = 4'hB → seg_n = 0111111 while com_n[2] is low. Default DP_MASK: dp_n = 0 only while com_n[2] is low.
5. Async reset: assert reset_n while position 3 is lit → com_n = 111111 and seg_n = 7F within the same cycle, with no clock edge. After release the scan restarts at d.
6. Leading zeros: d = e = f = 0, g = 4, h = 0, i = 0.
   - With SEG7_LZ_BLANK_EN: positions 5..3 show seg_n = 7F, positions 1 and 0 show 1000000.
   - Without it: all zero positions show 1000000.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 6-digit multiplexed 7-segment display driver.
// Segment codes are active-low, bit0 = a ... bit6 = g.
package seg7_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // Digit position: 5 = leftmost (d) down to 0 = rightmost (i).
  typedef logic [2:0] pos_t;

  localparam pos_t POS_FIRST = 3'd5;
  localparam pos_t POS_LAST  = 3'd0;

  // Active-low common pattern that enables exactly one position.
  function automatic logic [NUM_DIGITS-1:0] com_mask(input pos_t p);
    return ~(NUM_DIGITS'(1) << p);
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low 7-segment decoder; values 10..15 show a dash.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Stopwatch display back end: latches a six-digit frame once per scan and multiplexes it
// onto a common-anode FND with a blank gap per slot. Define SEG7_LZ_BLANK_EN for leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int          SCAN_DIV  = 50000,
  parameter int          BLANK_CYC = 2,
  parameter logic [5:0]  DP_MASK   = 6'b000100
)
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] d,
  input  logic [3:0] e,
  input  logic [3:0] f,
  input  logic [3:0] g,
  input  logic [3:0] h,
  input  logic [3:0] i,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [5:0] com_n
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYC);

  logic [PW-1:0]                 r_presc;
  pos_t                          r_idx;
  logic [BW-1:0]                 r_blank;
  logic                          r_started;
  logic [NUM_DIGITS-1:0][3:0]    r_frame;
  logic [NUM_DIGITS-1:0]         r_lz;
  logic [6:0]                    r_seg;
  logic                          r_dp;
  logic [NUM_DIGITS-1:0]         r_com;

  logic                          w_tick;
  logic                          w_wrap;
  pos_t                          w_next_idx;
  logic [NUM_DIGITS-1:0][3:0]    w_in_frame;
  logic [NUM_DIGITS-1:0]         w_in_lz;
  logic [3:0]                    w_digit;
  logic                          w_lz_sel;
  logic [6:0]                    w_dec;

  assign w_in_frame = {d, e, f, g, h, i};
  assign w_tick     = (r_presc == PRESC_MAX);
  // The first tick after reset is treated as a wrap so the scan always opens on d with a fresh frame.
  assign w_wrap     = (r_idx == POS_LAST) || !r_started;
  assign w_next_idx = w_wrap ? POS_FIRST : (r_idx - 3'd1);

`ifdef SEG7_LZ_BLANK_EN
  always_comb begin
    w_in_lz    = '0;
    w_in_lz[5] = (d == 4'd0);
    w_in_lz[4] = (d == 4'd0) && (e == 4'd0);
    w_in_lz[3] = (d == 4'd0) && (e == 4'd0) && (f == 4'd0);
    w_in_lz[2] = (d == 4'd0) && (e == 4'd0) && (f == 4'd0) && (g == 4'd0);
  end
`else
  assign w_in_lz = '0;
`endif

  // On a wrap the frame registers are stale, so the leftmost slot decodes the live inputs.
  assign w_digit  = w_wrap ? w_in_frame[w_next_idx] : r_frame[w_next_idx];
  assign w_lz_sel = w_wrap ? w_in_lz[w_next_idx]    : r_lz[w_next_idx];

  seg7_decoder u_decoder (
    .i_bcd (w_digit),
    .o_seg (w_dec)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc   <= '0;
      r_idx     <= POS_FIRST;
      r_started <= 1'b0;
    end else if (w_tick) begin
      r_presc   <= '0;
      r_idx     <= w_next_idx;
      r_started <= 1'b1;
    end else begin
      r_presc   <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame <= '0;
      r_lz    <= '0;
    end else if (w_tick && w_wrap) begin
      r_frame <= w_in_frame;
      r_lz    <= w_in_lz;
    end
  end

  // Commons go dark at every slot change and re-enable once the blank counter runs out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blank <= '0;
      r_com   <= '1;
    end else if (w_tick) begin
      r_blank <= BLANK_LOAD;
      r_com   <= (BLANK_CYC == 0) ? com_mask(w_next_idx) : '1;
    end else if (r_blank != '0) begin
      r_blank <= r_blank - 1'b1;
      if (r_blank == BW'(1)) begin
        r_com <= com_mask(r_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else if (w_tick) begin
      r_seg <= w_lz_sel ? SEG_OFF : w_dec;
      r_dp  <= w_lz_sel ? 1'b1 : ~DP_MASK[w_next_idx];
    end
  end

  assign seg_n = r_seg;
  assign dp_n  = r_dp;
  assign com_n = r_com;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (SCAN_DIV = 4, BLANK_CYC = 1, 20 ns clock).
// Expected slot contents are queued when digits are driven and popped as each slot lights.
module tb_seg7_scan_driver;

  localparam int         SCAN_DIV   = 4;
  localparam int         BLANK_CYC  = 1;
  localparam logic [5:0] DP_MASK_TB = 6'b000100;
  localparam int         LIT_CYC    = SCAN_DIV - BLANK_CYC;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] d = '0, e = '0, f = '0, g = '0, h = '0, i = '0;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [5:0] com_n;

  typedef struct packed {
    logic [5:0] com;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  always #10 clk = ~clk;

  seg7_scan_driver #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC),
    .DP_MASK   (DP_MASK_TB)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (d),
    .e       (e),
    .f       (f),
    .g       (g),
    .h       (h),
    .i       (i),
    .seg_n   (seg_n),
    .dp_n    (dp_n),
    .com_n   (com_n)
  );

  function automatic logic [6:0] modelSeg(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic applyStimulus(input logic [23:0] fr);
    {d, e, f, g, h, i} = fr;
  endtask

  // Queue the six slots of one frame in scan order d..i.
  function automatic void pushFrame(input logic [23:0] fr);
    exp_t       ex;
    logic [3:0] dig;
    logic       blankIt;
`ifdef SEG7_LZ_BLANK_EN
    logic       lzRun = 1'b1;
`endif
    for (int p = 5; p >= 0; p--) begin
      dig     = fr[p*4 +: 4];
      blankIt = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
      if (p >= 2) begin
        lzRun   = lzRun && (dig == 4'd0);
        blankIt = lzRun;
      end
`endif
      ex.com    = 6'h3F;
      ex.com[p] = 1'b0;
      ex.seg    = blankIt ? 7'h7F : modelSeg(dig);
      ex.dp     = blankIt ? 1'b1 : ~DP_MASK_TB[p];
      expQ.push_back(ex);
    end
  endfunction

  // Wait for position 0 to light, then stop on the blank that opens the next frame.
  task automatic syncToFrame();
    int n = 0;
    while (com_n !== 6'b111110 && n < 200) begin n++; @(negedge clk); end
    compared++;
    if (n >= 200) begin
      mismatched++;
      $display("[TB] FAIL sync_pos0: com_n got %b required 111110 within 200 cycles", com_n);
    end
    n = 0;
    while (com_n !== 6'h3F && n < 20) begin n++; @(negedge clk); end
  endtask

  // Called on a blank negedge; checks blank length, slot contents and lit length.
  task automatic scanSlot(input bit midChange);
    int         blanks = 0;
    int         lit = 0;
    exp_t       ex;
    logic [5:0] litCom;
    while (com_n === 6'h3F && blanks < 20) begin blanks++; @(negedge clk); end
    compared++;
    if (blanks != BLANK_CYC) begin
      mismatched++;
      $display("[TB] FAIL blank_len: got %0d required %0d", blanks, BLANK_CYC);
    end
    compared++;
    if (expQ.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL queue_empty: got 0 entries required at least 1");
      return;
    end
    ex = expQ.pop_front();
    compared++;
    if (com_n !== ex.com) begin
      mismatched++;
      $display("[TB] FAIL slot_com: got %b required %b", com_n, ex.com);
    end
    compared++;
    if (seg_n !== ex.seg) begin
      mismatched++;
      $display("[TB] FAIL slot_seg (com %b): got %b required %b", ex.com, seg_n, ex.seg);
    end
    compared++;
    if (dp_n !== ex.dp) begin
      mismatched++;
      $display("[TB] FAIL slot_dp (com %b): got %b required %b", ex.com, dp_n, ex.dp);
    end
    if (midChange) begin
      applyStimulus({6{4'd9}});
      pushFrame({6{4'd9}});
    end
    litCom = com_n;
    while (com_n === litCom && lit < 20) begin lit++; @(negedge clk); end
    compared++;
    if (lit != LIT_CYC) begin
      mismatched++;
      $display("[TB] FAIL lit_len (com %b): got %0d required %0d", litCom, lit, LIT_CYC);
    end
  endtask

  // Called right after reset release on a negedge: first lit slot is d at clock SCAN_DIV+BLANK_CYC.
  task automatic checkStartup();
    for (int k = 1; k <= SCAN_DIV + BLANK_CYC; k++) begin
      @(negedge clk);
      compared++;
      if (k < SCAN_DIV + BLANK_CYC) begin
        if (com_n !== 6'h3F) begin
          mismatched++;
          $display("[TB] FAIL startup_dark clk %0d: com_n got %b required 111111", k, com_n);
        end
      end else begin
        if (com_n !== 6'b011111 || seg_n !== modelSeg(d)) begin
          mismatched++;
          $display("[TB] FAIL startup_first: com_n/seg_n got %b/%b required 011111/%b",
                   com_n, seg_n, modelSeg(d));
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    applyStimulus({4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6});
    repeat (3) begin
      @(negedge clk);
      compared++;
      if ({com_n, seg_n, dp_n} !== {6'h3F, 7'h7F, 1'b1}) begin
        mismatched++;
        $display("[TB] FAIL reset_state: com/seg/dp got %b/%b/%b required 111111/1111111/1",
                 com_n, seg_n, dp_n);
      end
    end
    reset_n = 1'b1;
    checkStartup();
  endtask

  task automatic test_static();
    applyStimulus({4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6});
    expQ.delete();
    pushFrame({4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6});
    syncToFrame();
    repeat (6) scanSlot(1'b0);
  endtask

  task automatic test_tearing();
    applyStimulus({4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6});
    expQ.delete();
    pushFrame({4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6});
    syncToFrame();
    scanSlot(1'b0);
    scanSlot(1'b0);
    scanSlot(1'b1);
    repeat (9) scanSlot(1'b0);
  endtask

  task automatic test_invalid_bcd();
    applyStimulus({4'd1, 4'd2, 4'd3, 4'hB, 4'd5, 4'd6});
    expQ.delete();
    pushFrame({4'd1, 4'd2, 4'd3, 4'hB, 4'd5, 4'd6});
    syncToFrame();
    repeat (6) scanSlot(1'b0);
  endtask

  task automatic test_async_reset();
    int n = 0;
    applyStimulus({4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2});
    expQ.delete();
    pushFrame({4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2});
    syncToFrame();
    scanSlot(1'b0);
    scanSlot(1'b0);
    while (com_n === 6'h3F && n < 20) begin n++; @(negedge clk); end
    compared++;
    if (com_n !== 6'b110111) begin
      mismatched++;
      $display("[TB] FAIL pre_reset_pos3: com_n got %b required 110111", com_n);
    end
    #3;
    reset_n = 1'b0;
    #1;
    compared++;
    if ({com_n, seg_n, dp_n} !== {6'h3F, 7'h7F, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL async_reset: com/seg/dp got %b/%b/%b required 111111/1111111/1",
               com_n, seg_n, dp_n);
    end
    expQ.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    checkStartup();
  endtask

  task automatic test_leading_zeros();
    applyStimulus({4'd0, 4'd0, 4'd0, 4'd4, 4'd0, 4'd0});
    expQ.delete();
    pushFrame({4'd0, 4'd0, 4'd0, 4'd4, 4'd0, 4'd0});
    syncToFrame();
    repeat (6) scanSlot(1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] seg7_scan_driver bench start");
    test_reset();
    test_static();
    test_tearing();
    test_invalid_bcd();
    test_async_reset();
    test_leading_zeros();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
